// File: rtl/hermes_buffered_crossbar_pkg.sv
// Shared constants and types for the Hermes buffered crossbar.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default router geometry, output slot depth, port-index type and width helper.
package hermes_buffered_crossbar_pkg;

  localparam int HERMES_XBAR_NPORT      = 5;
  localparam int HERMES_XBAR_FLIT_SIZE  = 32;
  localparam int HERMES_XBAR_SLOT_DEPTH = 2;

  // Index width for a port count; a 1-bit field is kept even for degenerate counts.
  function automatic int pidx_width(input int nport);
    return (nport > 1) ? $clog2(nport) : 1;
  endfunction

  typedef logic [$clog2(HERMES_XBAR_NPORT)-1:0] pidx_t;

endpackage

// File: rtl/hermes_buffered_crossbar_if.sv
// Bundle of the crossbar's allocator, input-buffer and output-link signals.
// Latency: n/a (wiring only).
// Backpressure: credit_i from downstream, ack_o back to the input buffers.
// Modports: master = router environment (drives inputs), slave = crossbar.
// flit_cnt_o exists only when HERMES_XBAR_STATS_EN is defined.
interface hermes_buffered_crossbar_if
  import hermes_buffered_crossbar_pkg::*;
#(
  parameter int NPORT     = HERMES_XBAR_NPORT,
  parameter int FLIT_SIZE = HERMES_XBAR_FLIT_SIZE
`ifdef HERMES_XBAR_STATS_EN
  , parameter int CNT_W   = 32
`endif
);

  localparam int PIDX_W = pidx_width(NPORT);

  logic [NPORT-1:0]                 data_av_i;
  logic [NPORT-1:0][FLIT_SIZE-1:0]  data_i;
  logic [NPORT-1:0]                 ack_o;
  logic [NPORT-1:0][PIDX_W-1:0]     outport_i;
  logic [NPORT-1:0][PIDX_W-1:0]     inport_i;
  logic [NPORT-1:0]                 free_i;
  logic [NPORT-1:0]                 credit_i;
  logic [NPORT-1:0]                 tx_o;
  logic [NPORT-1:0][FLIT_SIZE-1:0]  data_o;
`ifdef HERMES_XBAR_STATS_EN
  logic [NPORT-1:0][CNT_W-1:0]      flit_cnt_o;
`endif

  modport master (
    output data_av_i, data_i, outport_i, inport_i, free_i, credit_i,
    input  ack_o, tx_o, data_o
`ifdef HERMES_XBAR_STATS_EN
    , input flit_cnt_o
`endif
  );

  modport slave (
    input  data_av_i, data_i, outport_i, inport_i, free_i, credit_i,
    output ack_o, tx_o, data_o
`ifdef HERMES_XBAR_STATS_EN
    , output flit_cnt_o
`endif
  );

endinterface

// File: rtl/hermes_buffered_crossbar_slot.sv
// Generic small FIFO used as the registered output slot of one crossbar output.
// Latency: pushed entry visible at dout_o/vld_o the cycle after the push.
// Backpressure: full_o is purely registered; a push while full is dropped, a pop while empty is ignored.
// Ports: clk_i, rst_i (async active-high), push_i/din_i, pop_i, full_o, vld_o, dout_o ('0 when empty).
module hermes_buffered_crossbar_slot #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         vld_o,
  output logic [W-1:0] dout_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign vld_o   = (count_q != '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && vld_o;
  assign dout_o  = vld_o ? mem[rd_ptr_q] : '0;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed through a valid count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/hermes_buffered_crossbar.sv
// Hermes router crossbar with a registered FIFO slot on every output.
// Latency: a flit acked in cycle N is presented on tx_o/data_o in cycle N+1; 1 flit/cycle/output.
// Backpressure: ack_o depends only on registered slot occupancy; credit_i drains slots and never reaches ack_o.
// Ports: clk_i, rst_i (async active-high), xb (hermes_buffered_crossbar_if.slave).
// Optional: HERMES_XBAR_STATS_EN adds saturating per-output flit counters on xb.flit_cnt_o.
module hermes_buffered_crossbar
  import hermes_buffered_crossbar_pkg::*;
#(
  parameter int NPORT      = HERMES_XBAR_NPORT,
  parameter int FLIT_SIZE  = HERMES_XBAR_FLIT_SIZE,
  parameter int SLOT_DEPTH = HERMES_XBAR_SLOT_DEPTH
`ifdef HERMES_XBAR_STATS_EN
  , parameter int CNT_W    = 32
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  hermes_buffered_crossbar_if.slave xb
);

  localparam int PIDX_W = pidx_width(NPORT);

  logic [NPORT-1:0]                push;
  logic [NPORT-1:0]                pop;
  logic [NPORT-1:0]                ack;
  logic [NPORT-1:0]                slot_full;
  logic [NPORT-1:0]                slot_vld;
  logic [NPORT-1:0][FLIT_SIZE-1:0] push_dat;
  logic [NPORT-1:0][FLIT_SIZE-1:0] slot_dat;

  // A pair (i, o) is connected only when both allocator views agree:
  // inport_i[o] names i and outport_i[i] names o. Out-of-range indices never
  // match any loop value, so they fall out as "no connection". Transfers are
  // held off while reset is asserted so ack_o reads 0 during reset.
  always_comb begin
    push     = '0;
    ack      = '0;
    push_dat = '0;
    for (int o = 0; o < NPORT; o++) begin
      for (int i = 0; i < NPORT; i++) begin
        if (!rst_i && !xb.free_i[o] &&
            xb.inport_i[o] == PIDX_W'(i) && xb.outport_i[i] == PIDX_W'(o)) begin
          push_dat[o] = xb.data_i[i];
          if (xb.data_av_i[i] && !slot_full[o]) begin
            push[o] = 1'b1;
            ack[i]  = 1'b1;
          end
        end
      end
    end
  end

  assign pop      = slot_vld & xb.credit_i;
  assign xb.ack_o = ack;
  assign xb.tx_o  = slot_vld;

  for (genvar o = 0; o < NPORT; o++) begin : g_slot
    hermes_buffered_crossbar_slot #(
      .DEPTH (SLOT_DEPTH),
      .W     (FLIT_SIZE)
    ) u_slot (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (push[o]),
      .pop_i  (pop[o]),
      .din_i  (push_dat[o]),
      .full_o (slot_full[o]),
      .vld_o  (slot_vld[o]),
      .dout_o (slot_dat[o])
    );
    assign xb.data_o[o] = slot_dat[o];
  end

`ifdef HERMES_XBAR_STATS_EN
  logic [NPORT-1:0][CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        if (pop[o] && cnt_q[o] != '1) cnt_q[o] <= cnt_q[o] + CNT_W'(1);
      end
    end
  end

  assign xb.flit_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_hermes_buffered_crossbar.sv
// Directed bench for hermes_buffered_crossbar: reset, single hop, backpressure,
// full rate, release/reconnect, out-of-range indices, async reset mid-stream
// and (with HERMES_XBAR_STATS_EN) saturating counters.
module tb_hermes_buffered_crossbar;
  import hermes_buffered_crossbar_pkg::*;

  localparam int NPORT     = 5;
  localparam int FLIT_SIZE = 32;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  hermes_buffered_crossbar_if #(
    .NPORT     (NPORT),
    .FLIT_SIZE (FLIT_SIZE)
`ifdef HERMES_XBAR_STATS_EN
    , .CNT_W   (4)
`endif
  ) xb ();

  hermes_buffered_crossbar #(
    .NPORT      (NPORT),
    .FLIT_SIZE  (FLIT_SIZE),
    .SLOT_DEPTH (2)
`ifdef HERMES_XBAR_STATS_EN
    , .CNT_W    (4)
`endif
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .xb    (xb)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  // Backpressure table: per cycle credit on output 2, expected ack_o[0],
  // tx_o[2] and index of the flit expected at data_o[2].
  bit exp_ack3 [9] = '{1, 1, 0, 0, 0, 1, 1, 0, 0};
  bit cred3    [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
  bit exp_tx3  [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  int exp_d3   [9] = '{0, 0, 0, 0, 0, 1, 2, 3, 0};

  int idx [NPORT];
  int rx  [NPORT];
  int k3;

  function automatic logic [31:0] flit(input int i, input int k);
    return 32'hA000_0000 | (32'(i) << 16) | 32'(k);
  endfunction

  task automatic idle();
    xb.data_av_i = '0;
    xb.data_i    = '0;
    xb.free_i    = '1;
    xb.credit_i  = '0;
    xb.outport_i = '1;
    xb.inport_i  = '1;
  endtask

  task automatic connect(input int i, input int o);
    xb.outport_i[i] = pidx_t'(o);
    xb.inport_i[o]  = pidx_t'(i);
    xb.free_i[o]    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- 1. reset with data offered ----------------
    rst_i = 1'b1;
    idle();
    xb.data_av_i = '1;
    xb.credit_i  = '1;
    connect(0, 0);
    #12;
    chk("rst_tx", xb.tx_o === 5'b00000);
    chk("rst_ack", xb.ack_o === 5'b00000);
    chk("rst_data", xb.data_o === {NPORT*FLIT_SIZE{1'b0}});
    rst_i = 1'b0;
    idle();
    tick();
    chk("post_rst_tx", xb.tx_o === 5'b00000);
    chk("post_rst_data", xb.data_o === {NPORT*FLIT_SIZE{1'b0}});

    // ---------------- 2. single hop 0 -> 2 ----------------
    connect(0, 2);
    xb.data_i[0]    = 32'hCAFE0001;
    xb.data_av_i[0] = 1'b1;
    xb.credit_i[2]  = 1'b1;
    #1;
    chk("hop_ack", xb.ack_o === 5'b00001);
    chk("hop_tx_same_cycle", xb.tx_o === 5'b00000);
    tick();
    xb.data_av_i[0] = 1'b0;
    #1;
    chk("hop_tx", xb.tx_o === 5'b00100);
    chk("hop_data", xb.data_o[2] === 32'hCAFE0001);
    chk("hop_ack_idle", xb.ack_o === 5'b00000);
    tick();
    chk("hop_drained", xb.tx_o === 5'b00000);

    // ---------------- 3. backpressure on output 2 ----------------
    k3 = 0;
    for (int c = 0; c < 9; c++) begin
      xb.credit_i[2]  = cred3[c];
      xb.data_av_i[0] = (k3 < 4);
      xb.data_i[0]    = 32'hB300_0000 + 32'(k3);
      #1;
      chk("bp_ack", xb.ack_o[0] === exp_ack3[c]);
      chk("bp_tx", xb.tx_o[2] === exp_tx3[c]);
      chk("bp_data", xb.data_o[2] === (exp_tx3[c] ? 32'hB300_0000 + 32'(exp_d3[c]) : 32'h0));
      if (xb.ack_o[0]) k3++;
      tick();
    end
    chk("bp_acks_total", k3 == 4);

    // ---------------- 4. full rate, 5 disjoint connections ----------------
    idle();
    for (int i = 0; i < NPORT; i++) begin
      connect(i, (i + 1) % NPORT);
      idx[i] = 0;
      rx[i]  = 0;
    end
    xb.credit_i = '1;
    for (int c = 0; c < 101; c++) begin
      for (int i = 0; i < NPORT; i++) begin
        xb.data_av_i[i] = (idx[i] < 100);
        xb.data_i[i]    = flit(i, idx[i]);
      end
      #1;
      for (int o = 0; o < NPORT; o++) begin
        if (xb.tx_o[o]) begin
          chk("rate_order", xb.data_o[o] === flit((o + NPORT - 1) % NPORT, rx[o]));
          rx[o]++;
        end
      end
      for (int i = 0; i < NPORT; i++) begin
        if (xb.ack_o[i]) idx[i]++;
      end
      tick();
    end
    for (int o = 0; o < NPORT; o++) begin
      chk("rate_count", rx[o] == 100);
    end
    chk("rate_empty", xb.tx_o === 5'b00000);

    // ---------------- 5. release / reconnect on output 2 ----------------
    idle();
    connect(0, 2);
    xb.data_av_i[0] = 1'b1;
    xb.data_i[0]    = 32'hB0B0_0000;
    #1;
    chk("rel_ack0", xb.ack_o === 5'b00001);
    tick();
    xb.data_i[0] = 32'hB0B0_0001;
    #1;
    chk("rel_ack1", xb.ack_o === 5'b00001);
    tick();
    xb.free_i[2]   = 1'b1;
    xb.credit_i[2] = 1'b1;
    xb.data_i[0]   = 32'hB0B0_0002;
    #1;
    chk("rel_free_noack", xb.ack_o === 5'b00000);
    chk("rel_old0", xb.data_o[2] === 32'hB0B0_0000);
    tick();
    xb.inport_i[2]  = pidx_t'(3);
    xb.outport_i[3] = pidx_t'(2);
    xb.free_i[2]    = 1'b0;
    xb.data_i[3]    = 32'hC0C0_0003;
    xb.data_av_i[3] = 1'b1;
    #1;
    chk("rel_new_ack", xb.ack_o === 5'b01000);
    chk("rel_old1", xb.data_o[2] === 32'hB0B0_0001);
    tick();
    xb.data_av_i = '0;
    #1;
    chk("rel_new_data", xb.data_o[2] === 32'hC0C0_0003);
    tick();
    chk("rel_drained", xb.tx_o === 5'b00000);

    // ---------------- out-of-range indices ----------------
    idle();
    xb.free_i[1]    = 1'b0;
    xb.inport_i[1]  = pidx_t'(5);
    xb.outport_i[4] = pidx_t'(6);
    xb.inport_i[0]  = pidx_t'(4);
    xb.free_i[0]    = 1'b0;
    xb.data_av_i    = '1;
    xb.credit_i     = '1;
    #1;
    chk("oor_ack", xb.ack_o === 5'b00000);
    tick();
    chk("oor_tx", xb.tx_o === 5'b00000);

    // ---------------- 6. streaming, stats, async reset mid-stream ----------------
    idle();
    connect(0, 1);
    xb.credit_i[1]  = 1'b1;
    xb.data_av_i[0] = 1'b1;
    xb.data_i[0]    = 32'h5757_0000;
    for (int c = 0; c < 6; c++) tick();
    chk("stream_tx", xb.tx_o === 5'b00010);
`ifdef HERMES_XBAR_STATS_EN
    chk("stats_cnt5", xb.flit_cnt_o[1] === 4'h5);
`endif
    for (int c = 0; c < 16; c++) tick();
`ifdef HERMES_XBAR_STATS_EN
    chk("stats_sat", xb.flit_cnt_o[1] === 4'hF);
`endif
    #1;
    rst_i = 1'b1;
    #1;
    chk("arst_tx", xb.tx_o === 5'b00000);
    chk("arst_ack", xb.ack_o === 5'b00000);
    chk("arst_data", xb.data_o[1] === 32'h0);
`ifdef HERMES_XBAR_STATS_EN
    chk("arst_cnt", xb.flit_cnt_o[1] === 4'h0);
`endif
    xb.data_av_i = '0;
    #2;
    rst_i = 1'b0;
    tick();
    chk("arst_flushed", xb.tx_o === 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
